// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle, stalls EX while busy.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips iteration and returns results one cycle after start.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] part_rem, work_div, abs_dvs, raw_dvd;
  logic             neg_q, neg_r, dvs_zero;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial, rem_nxt, q_nxt;
  logic             q_bit, last_iter, accept, dvs_is_zero;

  // Magnitude of a two's complement operand when the operation is signed.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    rem_sh      = {part_rem, work_div[WIDTH-1]};
    q_bit       = (rem_sh >= {1'b0, abs_dvs});
    // The difference is only kept when it is below the divisor, so WIDTH bits suffice.
    trial       = rem_sh[WIDTH-1:0] - abs_dvs;
    rem_nxt     = q_bit ? trial : rem_sh[WIDTH-1:0];
    q_nxt       = {work_div[WIDTH-2:0], q_bit};
    last_iter   = (cnt == CNT_W'(WIDTH-1));
    accept      = start && !cancel;
    dvs_is_zero = (divisor == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (dvs_is_zero) state_nxt = DONE;
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cancel)         state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        result_valid = !cancel;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and final result write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      part_rem  <= '0;
      work_div  <= '0;
      abs_dvs   <= '0;
      raw_dvd   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvs_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            part_rem <= '0;
            work_div <= mag(dividend, signed_div);
            abs_dvs  <= mag(divisor, signed_div);
            raw_dvd  <= dividend;
            neg_q    <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= signed_div & dividend[WIDTH-1];
            dvs_zero <= dvs_is_zero;
`ifdef DIV_ZERO_FAST_EN
            if (dvs_is_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end
`endif
          end
        end
        BUSY: begin
          if (!cancel) begin
            part_rem <= rem_nxt;
            work_div <= q_nxt;
            cnt      <= cnt + 1'b1;
            if (last_iter) begin
              quotient  <= dvs_zero ? '1 : apply_sign(q_nxt, neg_q);
              remainder <= dvs_zero ? raw_dvd : apply_sign(rem_nxt, neg_r);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed MIPS corner cases, cancel/reset/start-while-busy, random ops.
module tb_div_sequencer;
  localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, signed_div = 1'b0, cancel = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         stall, result_valid;
  logic [W-1:0] quotient, remainder;

  div_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .stall(stall), .result_valid(result_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           at;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  logic [W-1:0] prev_q = '0, prev_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder takes dividend's sign.
  function automatic void model(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint la, lb, lq, lr;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sd) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = la / lb;
      lr = la % lb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (resetn && result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("valid_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Caller is positioned 1ns after a rising edge with the DUT in IDLE.
  // mode: 0 normal, 1 cancel at 10th BUSY cycle, 2 reset mid-BUSY, 3 extra start while BUSY.
  task automatic run_op(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    logic [W-1:0] eq, er;
    int t, lat, guard;
    exp_t e;
    model(sd, a, b, eq, er);
    lat = (b == '0) ? ZLAT : 33;
    start = 1'b1; signed_div = sd; dividend = a; divisor = b;
    t = cyc;
    if (mode == 0 || mode == 3) begin
      e.q = eq; e.r = er; e.at = t + lat;
      sb.push_back(e);
    end
    #1 check("stall_start", 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_div = ~sd;
    if (mode == 1) begin
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
      check("cancel_stall", 64'(stall), 64'd0);
      check("cancel_hold_q", 64'(quotient), 64'(prev_q));
      check("cancel_hold_r", 64'(remainder), 64'(prev_r));
      return;
    end
    if (mode == 2) begin
      repeat (5) @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_valid", 64'(result_valid), 64'd0);
      check("rst_q", 64'(quotient), 64'd0);
      check("rst_r", 64'(remainder), 64'd0);
      @(posedge clk); #1 resetn = 1'b1;
      prev_q = '0; prev_r = '0;
      return;
    end
    if (mode == 3) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1; dividend = 32'd55; divisor = 32'd5; signed_div = 1'b0;
      @(posedge clk); #1 start = 1'b0;
    end
    guard = 0;
    while (stall && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("stall_len", 64'(cyc - t), 64'(lat));
    @(posedge clk); #1;
    check("valid_pulse", 64'(result_valid), 64'd0);
    check("hold_q", 64'(quotient), 64'(eq));
    check("hold_r", 64'(remainder), 64'(er));
    prev_q = eq; prev_r = er;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b;
    logic sd;
    int sel;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_valid", 64'(result_valid), 64'd0);
    check("reset_q", 64'(quotient), 64'd0);
    check("reset_r", 64'(remainder), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, 0);
    run_op(1'b0, 32'h1234, 32'd0, 0);
    run_op(1'b1, 32'h80000005, 32'd0, 0);
    run_op(1'b0, 32'd100, 32'd7, 1);
    run_op(1'b0, 32'd9, 32'd3, 0);
    run_op(1'b0, 32'd1000, 32'd33, 3);
    run_op(1'b0, 32'd100, 32'd7, 2);
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, 0);

    for (int i = 0; i < 30; i++) begin
      sd  = 1'($urandom);
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = '0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'h80000000;
        3, 4:    b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (sel == 5) a = 32'h80000000;
      run_op(sd, a, b, 0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle iterative divider with its own control FSM, serving MIPS DIV/DIVU in the EX stage.
- Accepts one operation per start, stalls the pipeline while iterating, and returns quotient (LO) and remainder (HI) with a one-cycle valid pulse.
- Honours an exception/flush cancel.
- Radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request from decode/EX; sampled only in IDLE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- dividend  input  WIDTH  rs operand; captured with start.
- divisor  input  WIDTH  rt operand; captured with start.
- cancel  input  1  pipeline flush (exception/eret); aborts any operation.
- stall  output  1  hold upstream pipeline stages.
- result_valid  output  1  one-cycle pulse; quotient/remainder valid.
- quotient  output  WIDTH  LO result; held until next accepted start.
- remainder  output  WIDTH  HI result; held until next accepted start.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: state=IDLE, counter=0, stall=0, result_valid=0, quotient=0, remainder=0; internal shift registers are cleared to 0.
- States:
  - IDLE: start & !cancel -> BUSY. Capture operands; the working dividend is |dividend| if signed_div, else raw. Record neg_q = signed_div & (dividend[MSB] ^ divisor[MSB]) and neg_r = signed_div & dividend[MSB]. Clear the partial remainder and the counter.
  - BUSY: each cycle, shift {partial_rem, work_dividend} left by 1. Trial subtract |divisor| in WIDTH+1 bits. If non-negative, keep the difference and set the quotient bit to 1; else restore and set the bit to 0. Increment counter. When counter==WIDTH-1, the iteration is performed, the sign fix is applied, quotient/remainder registers are written, and the FSM goes to DONE.
  - DONE: result_valid=1 for exactly this cycle; then -> IDLE unconditionally.
- Sign fix: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r. Arithmetic is modulo 2^WIDTH, so 0x80000000 / 0xFFFFFFFF signed yields q=0x80000000, r=0 with no trap.
- Divide by zero (divisor==0): quotient=all ones, remainder=dividend (raw, unsigned and signed alike). Latency is per the Optional Feature.
- stall = (IDLE & start & !cancel) | BUSY. Combinational, so the issuing instruction is held in its start cycle. stall is 0 in DONE so EX advances with the result.
- Latency: start accepted at cycle T. BUSY occupies T+1..T+32, result_valid is high at T+33, and stall is high T..T+32 (33 cycles).
- start while BUSY or DONE: ignored.
- cancel:
  - In BUSY or DONE: -> IDLE next edge; result_valid is forced 0 in that cycle; quotient/remainder are not updated.
  - In IDLE with start: cancel wins, nothing is captured, stall=0.
- Reset mid-operation: immediate return to reset values; no result_valid.
- quotient/remainder are registered and change only at the BUSY->DONE transition (or the fast-zero path).

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: in IDLE, start with divisor==0 goes directly to DONE. stall is high only in the start cycle T; result_valid is at T+1 with the divide-by-zero values.
- Undefined: divide by zero runs the full 32 BUSY cycles (result_valid at T+33). The final registers are overridden with the same divide-by-zero values.
- Results are identical in both builds; only latency differs.

Test Plan:
- DIVU 100/7, start at T -> stall high T..T+32; result_valid at T+33 only; q=14, r=2; outputs held afterwards.
- DIV 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
- DIV 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- DIVU 0x1234/0 -> q=0xFFFFFFFF, r=0x1234. result_valid at T+1 with DIV_ZERO_FAST_EN, at T+33 without.
- Start 100/7, pulse cancel at the 10th BUSY cycle -> IDLE next edge, no result_valid, q/r keep prior values. New start 9/3 immediately after -> q=3, r=0 at its T+33.
- Start, then assert resetn=0 mid-BUSY (asynchronous, between edges) -> all outputs 0 immediately. start asserted during BUSY -> ignored, and the original result is still correct.
